// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression core running UNROLL rounds per clock, with an
// optional second pass over the digest for SHA-256d.
module sha256_iter_core #(
    parameter int UNROLL = 4,
    parameter int TAG_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_double,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [255:0]     rx_state,
    input  logic [511:0]     rx_input,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [255:0]     tx_hash
);
    localparam int R = 64 / UNROLL;

    localparam logic [255:0] IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Working state is packed with A in word 0 and H in word 7.
    function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] w,
                                               input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {h, g, f, e, d, c, b, a} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {g, f, e, d + t1, c, b, a, t1 + t2};
    endfunction

    // Word 0 of the window is always the W consumed by the current round.
    function automatic logic [511:0] sched_next(input logic [511:0] w);
        logic [31:0] w1, w14, s0, s1;
        w1  = w[63:32];
        w14 = w[479:448];
        s0  = rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3);
        s1  = rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10);
        return {s1 + w[319:288] + s0 + w[31:0], w[511:32]};
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic               pass_q, pass_d;
    logic [255:0]       hash_q, hash_d;
    logic [TAG_W-1:0]   otag_q, otag_d;
    logic [255:0]       st_q, st_d;
    logic [255:0]       init_q, init_d;
    logic [511:0]       w_q, w_d;
    logic               dbl_q, dbl_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    logic [255:0]       st_chain [UNROLL+1];
    logic [511:0]       w_chain  [UNROLL+1];
    logic [255:0]       final_sum;

    assign st_chain[0] = st_q;
    assign w_chain[0]  = w_q;

    // Rounds are chained combinationally; cnt*UNROLL+u always fits in six bits.
    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        logic [5:0] k_idx;
        assign k_idx         = cnt_q * 6'(UNROLL) + 6'(u);
        assign st_chain[u+1] = sha_round(st_chain[u], w_chain[u][31:0], K_TAB[k_idx]);
        assign w_chain[u+1]  = sched_next(w_chain[u]);
    end

    assign final_sum = add_words(init_q, st_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        hash_d  = hash_q;
        otag_d  = otag_q;
        st_d    = st_q;
        init_d  = init_q;
        w_d     = w_q;
        dbl_d   = dbl_q;
        tag_d   = tag_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = rx_state;
                    init_d  = rx_state;
                    w_d     = rx_input;
                    dbl_d   = in_double;
                    tag_d   = in_tag;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                st_d = st_chain[UNROLL];
                w_d  = w_chain[UNROLL];
                if (cnt_q == 6'(R - 1)) begin
                    cnt_d   = '0;
                    state_d = FINAL;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            FINAL: begin
                if (dbl_q && !pass_q) begin
                    // Second pass hashes the 32-byte digest as a single padded block.
                    pass_d  = 1'b1;
                    st_d    = IV;
                    init_d  = IV;
                    w_d     = {32'h00000100, 192'h0, 32'h80000000, final_sum};
                    state_d = RUN;
                end else begin
                    hash_d  = final_sum;
                    otag_d  = tag_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            hash_q  <= '0;
            otag_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            hash_q  <= hash_d;
            otag_q  <= otag_d;
        end
    end

    // Datapath registers are only observed after an accept loads them.
    always_ff @(posedge clk) begin
        st_q   <= st_d;
        init_q <= init_d;
        w_q    <= w_d;
        dbl_q  <= dbl_d;
        tag_q  <= tag_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign tx_hash   = hash_q;
    assign out_tag   = otag_q;

endmodule
